// File: rtl/por_job_scheduler.sv
// ---------------------------------------------------------------------------
// por_job_scheduler
//   Arbitrates the single SHA-256 PoR engine between two requesters:
//   timestamped veto events (rising edges of i_veto_in, buffered in a FIFO,
//   high priority) and periodic heartbeat attestations (low priority).
//   Completed hashes are returned with a source tag.
//
// Ports
//   i_clk, i_rst            fabric clock, synchronous active-high reset
//   i_veto_in               veto level; each rising edge is one event
//   i_attention_level[1:0]  level captured with each veto event
//   i_eng_busy              engine busy, blocks job issue
//   i_eng_done, i_eng_hash  engine completion pulse and result
//   o_job_start, o_job_data job issue pulse and {tag, level, 28'h0, ts}
//   o_por_valid, o_por_hash_out, o_por_tag   result pulse, hash, tag
//   o_drop_count            saturating count of events lost to a full FIFO
//   o_timeout_err           pulse when an engine job is abandoned
//
// TS_INIT is the timestamp reset value; it stays 0 in the product and only
// exists so a bench can reach the 32-bit wrap without billions of cycles.
// ---------------------------------------------------------------------------
module por_job_scheduler #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          HB_PERIOD   = 65536,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] TS_INIT     = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_veto_in,
    input  logic [1:0]  i_attention_level,
    input  logic        i_eng_busy,
    input  logic        i_eng_done,
    input  logic [31:0] i_eng_hash,
    output logic        o_job_start,
    output logic [63:0] o_job_data,
    output logic [31:0] o_por_hash_out,
    output logic        o_por_valid,
    output logic [1:0]  o_por_tag,
    output logic [15:0] o_drop_count,
    output logic        o_timeout_err
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int HBW = $clog2(HB_PERIOD);
    localparam int TW  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [31:0]     r_ts;
    logic            r_veto_q;
    logic [33:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr;
    logic [HBW-1:0]  r_hb_cnt;
    logic            r_hb_pending;
    logic [TW-1:0]   r_tcnt;
    logic            r_is_hb;
    logic [1:0]      r_job_lvl;
    logic [31:0]     r_job_ts;

    logic w_edge, w_empty, w_full, w_pop, w_push, w_drop, w_hb_wrap, w_hb_issue;

    assign w_edge  = i_veto_in & ~r_veto_q;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = (r_state == S_IDLE) && !i_eng_busy && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_edge && (!w_full || w_pop);
    assign w_drop  = w_edge && w_full && !w_pop;
    assign w_hb_wrap  = (r_hb_cnt == HBW'(HB_PERIOD - 1));
    assign w_hb_issue = (r_state == S_IDLE) && !i_eng_busy && w_empty && r_hb_pending;

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= {r_ts, i_attention_level};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_ts           <= TS_INIT;
            r_veto_q       <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_hb_cnt       <= '0;
            r_hb_pending   <= 1'b0;
            r_tcnt         <= '0;
            r_is_hb        <= 1'b0;
            r_job_lvl      <= 2'b00;
            r_job_ts       <= 32'h0;
            o_job_start    <= 1'b0;
            o_job_data     <= 64'h0;
            o_por_hash_out <= 32'h0;
            o_por_valid    <= 1'b0;
            o_por_tag      <= 2'b00;
            o_drop_count   <= 16'h0;
            o_timeout_err  <= 1'b0;
        end else begin
            r_ts     <= r_ts + 32'd1;
            r_veto_q <= i_veto_in;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop && o_drop_count != 16'hFFFF)
                o_drop_count <= o_drop_count + 16'd1;

            r_hb_cnt <= w_hb_wrap ? '0 : r_hb_cnt + 1'b1;
            // Wrap wins over issue so a period is never lost.
            if (w_hb_wrap)       r_hb_pending <= 1'b1;
            else if (w_hb_issue) r_hb_pending <= 1'b0;

            o_job_start   <= 1'b0;
            o_por_valid   <= 1'b0;
            o_timeout_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_is_hb              <= 1'b0;
                        {r_job_ts, r_job_lvl} <= r_mem[r_rd_ptr[AW-1:0]];
                        r_state              <= S_ISSUE;
                    end else if (w_hb_issue) begin
                        r_is_hb <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    o_job_start <= 1'b1;
                    o_job_data  <= r_is_hb ? {2'b10, 2'b00, 28'h0, r_ts}
                                           : {2'b01, r_job_lvl, 28'h0, r_job_ts};
                    r_tcnt      <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // Result outputs are registered here so they are valid
                    // during the DONE cycle, one cycle after eng_done.
                    if (i_eng_done) begin
                        o_por_valid    <= 1'b1;
                        o_por_hash_out <= i_eng_hash;
                        o_por_tag      <= r_is_hb ? 2'b10 : 2'b01;
                        r_state        <= S_DONE;
                    end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        o_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_por_job_scheduler.sv
module tb_por_job_scheduler;
    localparam int          FD  = 8;
    localparam int          HB  = 500;
    localparam int          TO  = 16;
    localparam logic [31:0] TS0 = 32'hFFFF_FF00;

    logic        clk = 1'b0, rst = 1'b1;
    logic        veto_in = 1'b0, eng_busy = 1'b0;
    logic [1:0]  lvl = 2'b00;
    logic        eng_done, man_done = 1'b0, resp_done = 1'b0;
    logic [31:0] eng_hash, man_hash = 32'h0, resp_hash = 32'h1234_5678;
    logic        job_start, por_valid, timeout_err;
    logic [63:0] job_data;
    logic [31:0] por_hash_out;
    logic [1:0]  por_tag;
    logic [15:0] drop_count;

    assign eng_done = man_done | resp_done;
    assign eng_hash = resp_done ? resp_hash : man_hash;

    por_job_scheduler #(.FIFO_DEPTH(FD), .HB_PERIOD(HB), .TIMEOUT_CYC(TO), .TS_INIT(TS0)) dut (
        .i_clk(clk), .i_rst(rst), .i_veto_in(veto_in), .i_attention_level(lvl),
        .i_eng_busy(eng_busy), .i_eng_done(eng_done), .i_eng_hash(eng_hash),
        .o_job_start(job_start), .o_job_data(job_data), .o_por_hash_out(por_hash_out),
        .o_por_valid(por_valid), .o_por_tag(por_tag), .o_drop_count(drop_count),
        .o_timeout_err(timeout_err));

    always #5 clk = ~clk;

    // Reference timestamp and cycle index of the next sampling posedge.
    logic [31:0] m_ts;
    int          m_cyc;
    always @(posedge clk) begin
        if (rst) begin m_ts <= TS0; m_cyc <= 0; end
        else begin m_ts <= m_ts + 32'd1; m_cyc <= m_cyc + 1; end
    end

    logic [63:0] jobs_q[$];
    logic [33:0] pors_q[$];
    always @(negedge clk) begin
        if (job_start) jobs_q.push_back(job_data);
        if (por_valid) pors_q.push_back({por_tag, por_hash_out});
    end

    // Engine model: answers each job after resp_dly cycles when enabled.
    bit resp_en = 1'b0;
    int resp_dly = 3;
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && job_start) begin
                repeat (resp_dly) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_job(input string nm, input int idx, input logic [63:0] exp);
        if (idx < jobs_q.size()) chk(nm, jobs_q[idx], exp);
        else                     chk(nm, {64{1'bx}}, exp);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; veto_in = 1'b0; eng_busy = 1'b0;
        @(negedge clk); rst = 1'b0;
        jobs_q.delete(); pors_q.delete();
    endtask

    task automatic wait_jobs(input int n, input int budget, input string nm);
        int c = 0;
        while (jobs_q.size() < n && c < budget) begin @(negedge clk); c++; end
        chk(nm, 64'(jobs_q.size()), 64'(n));
    endtask

    task automatic wait_pors(input int n, input int budget, input string nm);
        int c = 0;
        while (pors_q.size() < n && c < budget) begin @(negedge clk); c++; end
        chk(nm, 64'(pors_q.size()), 64'(n));
    endtask

    task automatic wait_ts(input logic [31:0] ts, input string nm);
        int c = 0;
        while (m_ts != ts && c < 1000) begin @(negedge clk); c++; end
        chk(nm, 64'(m_ts), 64'(ts));
    endtask

    task automatic wait_cyc(input int cyc, input string nm);
        int c = 0;
        while (m_cyc != cyc && c < 3000) begin @(negedge clk); c++; end
        chk(nm, 64'(m_cyc), 64'(cyc));
    endtask

    task automatic wait_start(input string nm);
        int c = 0;
        while (!job_start && c < 20) begin @(negedge clk); c++; end
        chk(nm, 64'(job_start), 64'd1);
    endtask

    typedef struct {
        logic        veto;
        logic [1:0]  lvl;
        logic        busy;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t tbl[20];
    int   hb_jobs;

    initial begin
        // Overflow table: 10 edges while the engine is busy; edges 8 and 9 drop.
        for (int i = 0; i < 10; i++) begin
            tbl[2*i]   = '{1'b1, 2'(i), 1'b1, (i >= 8) ? 16'(i - 7) : 16'd0};
            tbl[2*i+1] = '{1'b0, 2'(i), 1'b1, (i >= 8) ? 16'(i - 7) : 16'd0};
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_job_start", 64'(job_start), 64'd0);
        chk("rst_job_data", job_data, 64'd0);
        chk("rst_por_valid", 64'(por_valid), 64'd0);
        chk("rst_por_hash", 64'(por_hash_out), 64'd0);
        chk("rst_por_tag", 64'(por_tag), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);

        // T6: timestamp wrap, then merged heartbeat wraps
        do_reset();
        resp_en = 1'b1; resp_dly = 3;
        wait_ts(32'hFFFF_FFFF, "t6_reach_ts");
        veto_in = 1'b1; lvl = 2'b01;
        @(negedge clk); veto_in = 1'b0;
        @(negedge clk); veto_in = 1'b1; lvl = 2'b11;
        @(negedge clk); veto_in = 1'b0;
        wait_jobs(2, 100, "t6_jobs");
        chk_job("t6_job0", 0, {2'b01, 2'b01, 28'h0, 32'hFFFF_FFFF});
        chk_job("t6_job1", 1, {2'b01, 2'b11, 28'h0, 32'd1});
        wait_pors(2, 100, "t6_pors");
        eng_busy = 1'b1;
        wait_cyc(3*HB + 10, "t6_hold");
        jobs_q.delete();
        eng_busy = 1'b0;
        repeat (60) @(negedge clk);
        hb_jobs = 0;
        foreach (jobs_q[i]) if (jobs_q[i][63:62] == 2'b10) hb_jobs++;
        chk("t6_hb_merged", 64'(hb_jobs), 64'd1);
        chk("t6_total_jobs", 64'(jobs_q.size()), 64'd1);

        // T1: single veto at ts=100, latency and result path
        do_reset();
        resp_en = 1'b0;
        wait_ts(32'd100, "t1_reach_ts");
        veto_in = 1'b1; lvl = 2'b10;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n <= 4) chk($sformatf("t1_job_start_%0d", n), 64'(job_start), 64'(n == 3));
            if (n == 3) chk("t1_job_data", job_data, {2'b01, 2'b10, 28'h0, 32'd100});
            if (n == 8) begin man_done = 1'b1; man_hash = 32'hDEAD_BEEF; end
            if (n == 8) chk("t1_por_pre", 64'(por_valid), 64'd0);
            if (n == 9) begin
                man_done = 1'b0;
                chk("t1_por_valid", 64'(por_valid), 64'd1);
                chk("t1_por_hash", 64'(por_hash_out), 64'hDEAD_BEEF);
                chk("t1_por_tag", 64'(por_tag), 64'd1);
            end
            if (n == 10) begin
                chk("t1_por_pulse", 64'(por_valid), 64'd0);
                chk("t1_hash_hold", 64'(por_hash_out), 64'hDEAD_BEEF);
            end
        end
        repeat (10) @(negedge clk);
        veto_in = 1'b0;
        chk("t1_one_event", 64'(jobs_q.size()), 64'd1);

        // T2: overflow while busy, then push+pop on a full FIFO
        do_reset();
        resp_en = 1'b1; resp_dly = 2;
        foreach (tbl[i]) begin
            veto_in = tbl[i].veto; lvl = tbl[i].lvl; eng_busy = tbl[i].busy;
            @(negedge clk);
            chk($sformatf("t2_drop_%0d", i), 64'(drop_count), 64'(tbl[i].exp_drop));
            chk($sformatf("t2_nojob_%0d", i), 64'(job_start), 64'd0);
        end
        veto_in = 1'b1; lvl = 2'b11; eng_busy = 1'b0;
        @(negedge clk);
        veto_in = 1'b0;
        chk("t2_full_pushpop", 64'(drop_count), 64'd2);
        wait_jobs(9, 300, "t2_jobs");
        for (int i = 0; i < 8; i++)
            chk_job($sformatf("t2_job%0d", i), i, {2'b01, 2'(i), 28'h0, TS0 + 32'(2*i)});
        chk_job("t2_job8", 8, {2'b01, 2'b11, 28'h0, TS0 + 32'd20});

        // T3: veto beats pending heartbeat
        do_reset();
        eng_busy = 1'b1;
        wait_cyc(505, "t3_hold");
        veto_in = 1'b1; lvl = 2'b01;
        @(negedge clk); veto_in = 1'b0;
        @(negedge clk); eng_busy = 1'b0;
        wait_jobs(2, 100, "t3_jobs");
        chk_job("t3_veto_first", 0, {2'b01, 2'b01, 28'h0, TS0 + 32'd505});
        if (jobs_q.size() > 1) begin
            chk("t3_hb_tag_lvl", 64'(jobs_q[1][63:60]), 64'h8);
            chk("t3_hb_zero", 64'(jobs_q[1][59:32]), 64'd0);
        end
        repeat (60) @(negedge clk);
        chk("t3_hb_cleared", 64'(jobs_q.size()), 64'd2);
        if (pors_q.size() == 2) chk("t3_por_tags", 64'({pors_q[0][33:32], pors_q[1][33:32]}), 64'b0110);
        else                    chk("t3_por_count", 64'(pors_q.size()), 64'd2);

        // T4: engine timeout, next job still issued
        do_reset();
        resp_en = 1'b0;
        veto_in = 1'b1; lvl = 2'b00;
        @(negedge clk); veto_in = 1'b0;
        @(negedge clk); veto_in = 1'b1; lvl = 2'b11;
        @(negedge clk); veto_in = 1'b0;
        wait_start("t4_first_start");
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clk);
            if (k >= TO - 1) chk($sformatf("t4_timeout_%0d", k), 64'(timeout_err), 64'(k == TO));
        end
        wait_start("t4_second_start");
        chk("t4_second_job", job_data, {2'b01, 2'b11, 28'h0, TS0 + 32'd2});
        repeat (TO + 5) @(negedge clk);
        chk("t4_no_por", 64'(pors_q.size()), 64'd0);

        // T5: reset while in WAIT with events queued
        resp_en = 1'b1;
        veto_in = 1'b1; lvl = 2'b10;
        @(negedge clk); veto_in = 1'b0;
        wait_pors(1, 50, "t5_prior_done");
        resp_en = 1'b0;
        repeat (3) @(negedge clk);
        veto_in = 1'b1;
        @(negedge clk); veto_in = 1'b0;
        wait_start("t5_start");
        veto_in = 1'b1;
        @(negedge clk); veto_in = 1'b0;
        @(negedge clk); veto_in = 1'b1;
        @(negedge clk); veto_in = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        jobs_q.delete(); pors_q.delete();
        chk("t5_job_data", job_data, 64'd0);
        chk("t5_por_hash", 64'(por_hash_out), 64'd0);
        chk("t5_por_tag", 64'(por_tag), 64'd0);
        chk("t5_outs", 64'({job_start, por_valid, timeout_err}), 64'd0);
        man_done = 1'b1; man_hash = 32'hBAD0_BAD0;
        @(negedge clk); man_done = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5_late_done", 64'(pors_q.size()), 64'd0);
        chk("t5_fifo_flushed", 64'(jobs_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
